instr_fetch: RTL and testbench

Instruction fetch stage of the comp16 16-bit CPU, sitting directly downstream of the program counter. It takes the current fetch address from the PC and reads the instruction word from instruction memory over a req/ack handshake. It returns the word and its address to decode through a valid/ready interface, and pulses the PC's increment input once per instruction actually delivered. On a control-flow redirect (`flush`) it discards buffered and in-flight words and refetches from the new PC value.

---
 rtl/instr_fetch.sv | 198 +++++++++++++++++++
 tb/tb_instr_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: comp16 fetch stage; reads instruction words over a req/ack memory port and queues {word, addr} for decode.
// Latency: mem_req 1 cycle after the issue edge; ir_valid and incr 1 cycle after the mem_ack edge; 3 cycles per word with zero-wait memory.
// Backpressure: issue is credit-gated (buffered + in-flight < depth); INSTR_FETCH_PREFETCH_EN selects depth 2, otherwise depth 1.
module instr_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              incr,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc
);

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAITPC = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  count;
    logic        drop;
    logic        pc_ready;
    logic        issue;
    logic        ack_in;
    logic        push;
    logic        pop;
    logic [1:0]  count_after_pop;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic [DATA_W-1:0] slot_word;
    logic [ADDR_W-1:0] slot_addr;
`endif

    // The head entry lives directly in ir_out/ir_pc, so valid is just "buffer not empty".
    assign ir_valid = (count != 2'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control decode; a pop in the same cycle frees a slot for issue.
    always_comb begin
        state_nxt       = state;
        issue           = 1'b0;
        ack_in          = 1'b0;
        push            = 1'b0;
        pop             = ir_valid && ir_ready && !flush;
        count_after_pop = count - {1'b0, pop};
        case (state)
            IDLE: begin
                if ((count_after_pop < DEPTH) && pc_ready && !flush) begin
                    issue     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    ack_in    = 1'b1;
                    push      = !drop && !flush;
                    state_nxt = WAITPC;
                end
            end
            WAITPC: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory request: address captured at issue and held until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_in;
        end else if (ack_in) begin
            mem_req  <= 1'b0;
        end
    end

    // PC advance pulse; pc_ready blocks sampling pc_in until the PC has applied the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            incr     <= 1'b0;
            pc_ready <= 1'b1;
        end else begin
            incr <= push;
            if (push) begin
                pc_ready <= 1'b0;
            end else if (incr) begin
                pc_ready <= 1'b1;
            end
        end
    end

    // Drop flag: a flush during REQ cannot cancel the request, so the word it returns is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (ack_in) begin
            drop <= 1'b0;
        end else if (flush && (state == REQ)) begin
            drop <= 1'b1;
        end
    end

    // Instruction buffer: head in ir_out/ir_pc, optional second slot behind it; flush empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            ir_out <= '0;
            ir_pc  <= '0;
`ifdef INSTR_FETCH_PREFETCH_EN
            slot_word <= '0;
            slot_addr <= '0;
`endif
        end else if (flush) begin
            count  <= 2'd0;
            ir_out <= '0;
            ir_pc  <= '0;
        end else begin
            case ({push, pop})
`ifdef INSTR_FETCH_PREFETCH_EN
                2'b10: begin
                    if (count == 2'd0) begin
                        ir_out <= mem_rdata;
                        ir_pc  <= mem_addr;
                    end else begin
                        slot_word <= mem_rdata;
                        slot_addr <= mem_addr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        ir_out <= slot_word;
                        ir_pc  <= slot_addr;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ir_out <= mem_rdata;
                        ir_pc  <= mem_addr;
                    end else begin
                        ir_out    <= slot_word;
                        ir_pc     <= slot_addr;
                        slot_word <= mem_rdata;
                        slot_addr <= mem_addr;
                    end
                end
`else
                2'b10: begin
                    ir_out <= mem_rdata;
                    ir_pc  <= mem_addr;
                    count  <= 2'd1;
                end
                2'b01: begin
                    count <= 2'd0;
                end
                2'b11: begin
                    ir_out <= mem_rdata;
                    ir_pc  <= mem_addr;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch covering reset, fetch latency, backpressure, flush and mid-request reset.
// Inputs are driven 1 time unit after each rising edge and outputs are sampled at that same point.
// Expectations follow the build: INSTR_FETCH_PREFETCH_EN selects buffer depth 2, otherwise depth 1.
module tb_instr_fetch;

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_in = 16'h0000;
    logic        incr;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;

    int checks = 0;
    int errors = 0;

    int          incr_cnt = 0;
    int          req_rise = 0;
    int          stab_err = 0;
    int          bad_seen = 0;
    logic        req_q = 1'b0;
    logic [15:0] addr_q = 16'h0000;
    logic [15:0] popped[$];
    logic [15:0] exp_pop[5];

    instr_fetch #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc_in),
        .incr     (incr),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .ir_out   (ir_out),
        .ir_pc    (ir_pc)
    );

    always #5 clk = ~clk;

    // Observe the bus at each edge: incr pulses, request rises, address stability, accepted words, discarded data.
    always @(posedge clk) begin
        if (incr === 1'b1) incr_cnt++;
        if (mem_req === 1'b1 && req_q !== 1'b1) req_rise++;
        if (mem_req === 1'b1 && req_q === 1'b1 && mem_addr !== addr_q) stab_err++;
        req_q  = mem_req;
        addr_q = mem_addr;
        if (ir_valid === 1'b1 && ir_ready && !flush && !rst) popped.push_back(ir_out);
        if (ir_valid === 1'b1 && (ir_out === 16'hDEAD || ir_out === 16'hBEEF)) bad_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_mem_req",  32'(mem_req),  32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_incr",     32'(incr),     32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_ir_out",   32'(ir_out),   32'h0);
        chk("rst_ir_pc",    32'(ir_pc),    32'h0);

        // Single fetch from 0x0010, zero-wait memory returning 0xA5A5
        rst   = 1'b0;
        pc_in = 16'h0010;
        tick();
        chk("t1_mem_req",  32'(mem_req),  32'h1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        mem_ack   = 1'b1;
        mem_rdata = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        chk("t1_ir_valid", 32'(ir_valid), 32'h1);
        chk("t1_ir_out",   32'(ir_out),   32'hA5A5);
        chk("t1_ir_pc",    32'(ir_pc),    32'h0010);
        chk("t1_incr",     32'(incr),     32'h1);
        chk("t1_req_drop", 32'(mem_req),  32'h0);
        pc_in = 16'h0011;
        tick();
        chk("t1_incr_end", 32'(incr),     32'h0);
        chk("t1_hold",     32'(ir_valid), 32'h1);

        // Decode stalled: depth 2 fetches one more word, depth 1 issues nothing
        tick();
        chk("t3_req",  32'(mem_req),  32'(PF));
        chk("t3_addr", 32'(mem_addr), (PF != 0) ? 32'h0011 : 32'h0010);
        mem_ack   = (PF != 0);
        mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        chk("t3_incr",    32'(incr),   32'(PF));
        chk("t3_head",    32'(ir_out), 32'hA5A5);
        chk("t3_head_pc", 32'(ir_pc),  32'h0010);
        tick();
        pc_in = (PF != 0) ? 16'h0012 : 16'h0011;
        tick();
        tick();
        tick();
        chk("t3_no_req",   32'(mem_req),  32'h0);
        chk("t3_req_cnt",  32'(req_rise), (PF != 0) ? 32'd2 : 32'd1);
        chk("t3_incr_cnt", 32'(incr_cnt), (PF != 0) ? 32'd2 : 32'd1);
        chk("t3_valid",    32'(ir_valid), 32'h1);
        ir_ready = 1'b1;
        tick();
        chk("t3_after_pop_valid", 32'(ir_valid), 32'(PF));
        chk("t3_second_word", 32'(ir_valid && ir_out == 16'h1111 && ir_pc == 16'h0011), 32'(PF));
        chk("t3_refill_req", 32'(mem_req), 32'h1);

        // Reset while a request is outstanding, then a late ack
        rst   = 1'b1;
        pc_in = 16'h0000;
        tick();
        chk("t6_mem_req",  32'(mem_req),  32'h0);
        chk("t6_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_incr",     32'(incr),     32'h0);
        chk("t6_ir_valid", 32'(ir_valid), 32'h0);
        chk("t6_ir_out",   32'(ir_out),   32'h0);
        chk("t6_ir_pc",    32'(ir_pc),    32'h0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("t6_ack_ignored_valid", 32'(ir_valid), 32'h0);
        chk("t6_ack_ignored_incr",  32'(incr),     32'h0);
        chk("t6_ack_ignored_out",   32'(ir_out),   32'h0);
        chk("t6_new_req",           32'(mem_req),  32'h1);

        // Four fetches with 3-cycle memory latency, decode always ready, PC counting 0..3
        begin
            int incr_base;
            incr_base = incr_cnt;
            for (int k = 0; k < 4; k++) begin
                chk("t2_addr", 32'(mem_addr), 32'(k));
                tick();
                tick();
                chk("t2_req_held", 32'(mem_req), 32'h1);
                mem_ack   = 1'b1;
                mem_rdata = 16'(32'h1000 + k);
                tick();
                mem_ack = 1'b0;
                chk("t2_valid", 32'(ir_valid), 32'h1);
                chk("t2_word",  32'(ir_out),   32'h1000 + 32'(k));
                chk("t2_pc",    32'(ir_pc),    32'(k));
                chk("t2_incr",  32'(incr),     32'h1);
                tick();
                chk("t2_popped", 32'(ir_valid), 32'h0);
                chk("t2_incr_low", 32'(incr), 32'h0);
                pc_in = 16'(k + 1);
                tick();
                chk("t2_reissue", 32'(mem_req), 32'h1);
            end
            chk("t2_incr_total", 32'(incr_cnt - incr_base), 32'd4);
            chk("t2_last_addr", 32'(mem_addr), 32'h0004);
        end

        // Flush during REQ: the returned 0xDEAD is discarded, then refetch from 0x0200
        flush = 1'b1;
        pc_in = 16'h0200;
        tick();
        flush = 1'b0;
        chk("t4_req_kept",  32'(mem_req),  32'h1);
        chk("t4_addr_kept", 32'(mem_addr), 32'h0004);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("t4_no_valid", 32'(ir_valid), 32'h0);
        chk("t4_no_incr",  32'(incr),     32'h0);
        chk("t4_req_done", 32'(mem_req),  32'h0);
        tick();
        chk("t4_no_incr_late", 32'(incr), 32'h0);
        tick();
        chk("t4_new_req",  32'(mem_req),  32'h1);
        chk("t4_new_addr", 32'(mem_addr), 32'h0200);

        // Flush and ack on the same edge
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        flush   = 1'b0;
        mem_ack = 1'b0;
        chk("t5_no_valid", 32'(ir_valid), 32'h0);
        chk("t5_no_incr",  32'(incr),     32'h0);
        chk("t5_req_done", 32'(mem_req),  32'h0);
        tick();
        chk("t5_no_incr_late", 32'(incr), 32'h0);

        // Flush together with a pop empties a full buffer
        pc_in    = 16'h0201;
        ir_ready = 1'b0;
        tick();
        chk("t7_addr", 32'(mem_addr), 32'h0201);
        mem_ack   = 1'b1;
        mem_rdata = 16'h3333;
        tick();
        mem_ack = 1'b0;
        chk("t7_valid", 32'(ir_valid), 32'h1);
        chk("t7_word",  32'(ir_out),   32'h3333);
        ir_ready = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        ir_ready = 1'b0;
        chk("t7_flushed", 32'(ir_valid), 32'h0);
        tick();
        chk("t7_reissue", 32'(mem_req), 32'h1);

        // Whole-run observations
        chk("addr_stable",  32'(stab_err), 32'd0);
        chk("no_dropped_word", 32'(bad_seen), 32'd0);
        chk("incr_total",   32'(incr_cnt), (PF != 0) ? 32'd7 : 32'd6);
        exp_pop[0] = 16'hA5A5;
        exp_pop[1] = 16'h1000;
        exp_pop[2] = 16'h1001;
        exp_pop[3] = 16'h1002;
        exp_pop[4] = 16'h1003;
        chk("pop_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < popped.size()) begin
                chk("pop_order", 32'(popped[i]), 32'(exp_pop[i]));
            end else begin
                chk("pop_missing", 32'(i), 32'(popped.size() + 5));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
